parametrised_register_file: RTL
===============================

PARAMETRISED_REGISTER_FILE -- requirements
Module: parametrised_register_file

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, meaning the width of each register in bits.
REQ-002 SHALL have parameter ADDR_WIDTH, default 5, meaning the register index width; depth = 2**ADDR_WIDTH.
REQ-003 SHALL have parameter NUM_READ, default 2, meaning the number of independent read ports (1..8).
REQ-004 SHALL have port clock, input, 1, the single clock; all state changes on its rising edge.
REQ-005 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-006 SHALL have port register_write, input, 1, write enable.
REQ-007 SHALL have port write_register, input, ADDR_WIDTH, write index.
REQ-008 SHALL have port write_data, input, DATA_WIDTH, write value.
REQ-009 SHALL have port mark_busy, input, 1, issue strobe: the destination named by mark_register now has a pending producer.
REQ-010 SHALL have port mark_register, input, ADDR_WIDTH, index to mark busy.
REQ-011 SHALL have port read_register, input, NUM_READ*ADDR_WIDTH, read indices, port k in bits [k*ADDR_WIDTH +: ADDR_WIDTH].
REQ-012 SHALL have port read_data, output, NUM_READ*DATA_WIDTH, read values, port k in bits [k*DATA_WIDTH +: DATA_WIDTH].
REQ-013 SHALL have port read_busy, output, NUM_READ, per-port flag: the addressed register awaits a write.
REQ-014 SHALL have port busy_count, output, ADDR_WIDTH+1, number of registers currently busy.

Function
REQ-015 SHALL read combinationally: read_data and read_busy for port k reflect read_register[k] in the same cycle, with no clock latency.
REQ-016 SHALL write write_data into write_register at the rising edge when register_write=1 and write_register!=0.
REQ-017 SHALL hardwire register 0: read_data=0 and read_busy=0 always, and ignore writes and marks to index 0.
REQ-018 SHALL hold one busy bit per register: set at the edge where mark_busy=1 (index!=0), cleared at the edge where register_write=1 to that index.
REQ-019 SHALL give mark priority when mark and write target the same index in the same cycle: data is written, and the busy bit ends at 1.
REQ-020 SHALL leave a register's busy bit at 1 when it is marked again while already busy, with busy_count unchanged.
REQ-021 SHALL leave a register's busy bit at 0 when it is written while not busy, with busy_count unchanged.
REQ-022 SHALL update busy_count as a registered counter: +1 per 0->1 transition and -1 per 1->0 transition, with net 0 when a mark and a write to different indices cancel.
REQ-023 SHALL never let busy_count wrap, because busy_count is bounded by 2**ADDR_WIDTH-1.
REQ-024 SHALL serve all NUM_READ ports, including ports addressing the same register, independently and identically.

Reset
REQ-025 SHALL, on reset=1, immediately and asynchronously clear all registers, all busy bits and busy_count to 0, regardless of the clock.
REQ-026 SHALL have reset override any write or mark in progress; none of them takes effect while reset=1.
REQ-027 SHALL drive read_data=0, read_busy=0 and busy_count=0 for every port after reset.

Configuration
REQ-028 SHALL, when macro REGFILE_BYPASS_EN is defined, forward same-cycle writes: a read port addressing write_register (!=0) while register_write=1 shows read_data=write_data, and read_busy=0 unless mark_busy targets that same index.
REQ-029 SHALL, when REGFILE_BYPASS_EN is undefined, have reads return the stored value and stored busy bit, so a written value becomes visible from the cycle after the edge.

Verification
REQ-030 SHALL cover: reset, then write x5=0xDEADBEEF, then read on port0=5 and port1=5 -> both ports 0xDEADBEEF, read_busy=0.
REQ-031 SHALL cover: write x0=0x12345678, then read 0 -> read_data=0; then mark x0 -> read_busy=0 and busy_count=0.
REQ-032 SHALL cover: mark x3, then mark x7 -> busy_count=2; write x3=0xA5 -> busy_count=1, read_busy(x3)=0, read_busy(x7)=1.
REQ-033 SHALL cover: mark x9 and write x9=0x55 in the same cycle -> x9=0x55, read_busy(x9)=1, busy_count incremented by 1.
REQ-034 SHALL cover: read x4 while writing x4=0x77 in the same cycle -> 0x77 with REGFILE_BYPASS_EN, old value without it; 0x77 in the next cycle either way.
REQ-035 SHALL cover: mark three registers, write one, then assert reset between clock edges -> all outputs 0 immediately, before the next clock edge.

Source files
------------

// File: rtl/parametrised_register_file.sv
// Multi-port register file with a per-register busy (scoreboard) bit and a
// running count of busy registers. Register 0 always reads as zero and is never busy.
// Optional feature: define REGFILE_BYPASS_EN to forward a same-cycle write
// (and the busy state it produces) to any read port addressing that register.
module parametrised_register_file #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int NUM_READ   = 2
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic                           register_write,
  input  logic [ADDR_WIDTH-1:0]          write_register,
  input  logic [DATA_WIDTH-1:0]          write_data,
  input  logic                           mark_busy,
  input  logic [ADDR_WIDTH-1:0]          mark_register,
  input  logic [NUM_READ*ADDR_WIDTH-1:0] read_register,
  output logic [NUM_READ*DATA_WIDTH-1:0] read_data,
  output logic [NUM_READ-1:0]            read_busy,
  output logic [ADDR_WIDTH:0]            busy_count
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] count_one = 1;

  logic [DATA_WIDTH-1:0] regs [DEPTH];
  logic [DEPTH-1:0]      busy;

  // Writes and marks aimed at index 0 are discarded up front.
  logic write_en;
  logic mark_en;
  logic same_target;
  assign write_en    = register_write && (write_register != '0);
  assign mark_en     = mark_busy && (mark_register != '0);
  assign same_target = write_en && mark_en && (write_register == mark_register);

  // Counter deltas: only real 0->1 and 1->0 transitions of a busy bit count.
  // A write that coincides with a mark to the same index never clears it.
  logic count_inc;
  logic count_dec;
  assign count_inc = mark_en && !busy[mark_register];
  assign count_dec = write_en && busy[write_register] && !same_target;

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_reg
      if (gi == 0) begin : g_zero
        assign regs[gi] = '0;
        assign busy[gi] = 1'b0;
      end else begin : g_live
        // Data storage for one register; cleared asynchronously on reset.
        always_ff @(posedge clock or posedge reset) begin
          if (reset) begin
            regs[gi] <= '0;
          end else if (write_en && (write_register == gi[ADDR_WIDTH-1:0])) begin
            regs[gi] <= write_data;
          end
        end

        // Busy bit: a mark sets it and wins over a same-cycle write, a write clears it.
        always_ff @(posedge clock or posedge reset) begin
          if (reset) begin
            busy[gi] <= 1'b0;
          end else if (mark_en && (mark_register == gi[ADDR_WIDTH-1:0])) begin
            busy[gi] <= 1'b1;
          end else if (write_en && (write_register == gi[ADDR_WIDTH-1:0])) begin
            busy[gi] <= 1'b0;
          end
        end
      end
    end
  endgenerate

  // Running busy count; at most DEPTH-1 registers can be busy, so it never wraps.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      busy_count <= '0;
    end else if (count_inc && !count_dec) begin
      busy_count <= busy_count + count_one;
    end else if (count_dec && !count_inc) begin
      busy_count <= busy_count - count_one;
    end
  end

  generate
    for (gi = 0; gi < NUM_READ; gi++) begin : g_read
      logic [ADDR_WIDTH-1:0] addr;
      logic [DATA_WIDTH-1:0] data;
      logic                  flag;
      assign addr = read_register[gi*ADDR_WIDTH +: ADDR_WIDTH];
      assign read_data[gi*DATA_WIDTH +: DATA_WIDTH] = data;
      assign read_busy[gi] = flag;

      // Combinational read; index 0 is forced to zero and never busy.
      always_comb begin
        data = '0;
        flag = 1'b0;
        if (addr != '0) begin
`ifdef REGFILE_BYPASS_EN
          if (write_en && (write_register == addr)) begin
            data = write_data;
            flag = mark_en && (mark_register == addr);
          end else begin
            data = regs[addr];
            flag = busy[addr];
          end
`else
          data = regs[addr];
          flag = busy[addr];
`endif
        end
      end
    end
  endgenerate

endmodule
